// File: rtl/scanchain_uart_host.sv
`default_nettype none
// ============================================================================
//  Module      : scanchain_uart_host
//  Description : Host side of the scan-over-UART link. Accepts one scan-write
//                command, streams it MSB byte first to the UART transmitter
//                as {pad zeros, reset, payload, addr}, then waits for the
//                one-byte accept/reject reply or a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module scanchain_uart_host #(
    parameter int ADDR_BITS      = 12,
    parameter int PAYLOAD_BITS   = 169,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_BITS-1:0]    cmd_addr,
    input  logic [PAYLOAD_BITS-1:0] cmd_payload,
    input  logic                    cmd_reset,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    resp_valid,
    output logic                    resp_accepted,
    output logic                    resp_error,
    output logic                    resp_timeout,
    output logic                    busy
);

    localparam int PKT_BYTES = (ADDR_BITS + PAYLOAD_BITS + 1 + 7) / 8;
    localparam int PKT_BITS  = 8 * PKT_BYTES;
    localparam int BCNT_W    = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int TCNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(PKT_BYTES - 1);
    localparam logic [TCNT_W-1:0] LAST_WAIT = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PKT_BITS-1:0] r_packet;
    logic [PKT_BITS-1:0] w_load;
    logic [BCNT_W-1:0]   r_byte_cnt;
    logic [TCNT_W-1:0]   r_wait_cnt;
    logic                r_resp_valid;
    logic                r_resp_accepted;
    logic                r_resp_error;
    logic                r_resp_timeout;
    logic                w_accept;
    logic                w_tx_fire;
    logic                w_resp_rx;
    logic                w_resp_to;

    // Assemble the packet image: addr in the low bits, zero padding on top.
    always_comb begin
        w_load = '0;
        w_load[ADDR_BITS+PAYLOAD_BITS:0] = {cmd_reset, cmd_payload, cmd_addr};
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and per-cycle event strobes.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_tx_fire = 1'b0;
        w_resp_rx = 1'b0;
        w_resp_to = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    w_tx_fire = 1'b1;
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A reply on the terminal count cycle takes priority over timeout.
                if (rx_valid) begin
                    w_resp_rx = 1'b1;
                    w_next    = S_IDLE;
                end else if (r_wait_cnt == LAST_WAIT) begin
                    w_resp_to = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Packet shifter, byte/timeout counters and single-cycle response flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_packet        <= '0;
            r_byte_cnt      <= '0;
            r_wait_cnt      <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_accepted <= 1'b0;
            r_resp_error    <= 1'b0;
            r_resp_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_packet   <= w_load;
                r_byte_cnt <= '0;
            end else if (w_tx_fire) begin
                r_packet   <= {r_packet[PKT_BITS-9:0], 8'h00};
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            r_resp_valid    <= w_resp_rx | w_resp_to;
            r_resp_accepted <= w_resp_rx && (rx_data == 8'h01);
            r_resp_error    <= w_resp_rx && (rx_data > 8'h01);
            r_resp_timeout  <= w_resp_to;
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign tx_valid      = (r_state == S_SEND);
    assign tx_data       = r_packet[PKT_BITS-1 -: 8];
    assign rx_ready      = 1'b1;
    assign resp_valid    = r_resp_valid;
    assign resp_accepted = r_resp_accepted;
    assign resp_error    = r_resp_error;
    assign resp_timeout  = r_resp_timeout;

endmodule
`default_nettype wire
